regfile_wb_arbiter: RTL

Shares the single write port of the 32×32 register file between two writeback requesters: the execute-stage result (ex) and the memory-load result (mem). Arbitrates with valid/ready handshakes and round-robin priority, and registers the winning write onto the register file's RegWrite/rd/writeBackData inputs. Exposes per-read-port pending flags so decode can stall on read-after-write hazards.

---
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Two requesters (ex, mem) compete through valid/ready handshakes with
// round-robin priority; the winner is registered onto RegWrite/rd/writeBackData.
// Writes to x0 are accepted immediately and dropped without touching priority.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_data,
  output logic            ex_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic            RegWrite,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] writeBackData,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_pending,
  output logic            rs2_pending
);

  // last_grant_q: 0 = ex won last, 1 = mem won last
  logic            last_grant_q, last_grant_d;
  logic            reg_write_q, reg_write_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic ex_real, ex_null, mem_real, mem_null;
  logic ex_grant, mem_grant;

  // Classify requests and pick the round-robin winner among real ones.
  always_comb begin
    ex_real   = ex_valid && (ex_rd != '0);
    ex_null   = ex_valid && (ex_rd == '0);
    mem_real  = mem_valid && (mem_rd != '0);
    mem_null  = mem_valid && (mem_rd == '0);
    // On a tie the requester that did not win last time goes first
    ex_grant  = ex_real && (!mem_real || last_grant_q);
    mem_grant = mem_real && (!ex_real || !last_grant_q);
    ex_ready  = ex_null || ex_grant;
    mem_ready = mem_null || mem_grant;
  end

  // Next-state for the output stage and priority pointer.
  always_comb begin
    reg_write_d  = 1'b0;
    rd_d         = rd_q;
    wb_data_d    = wb_data_q;
    last_grant_d = last_grant_q;
    if (ex_grant) begin
      reg_write_d  = 1'b1;
      rd_d         = ex_rd;
      wb_data_d    = ex_data;
      last_grant_d = 1'b0;
    end else if (mem_grant) begin
      reg_write_d  = 1'b1;
      rd_d         = mem_rd;
      wb_data_d    = mem_data;
      last_grant_d = 1'b1;
    end
  end

  // Output stage and priority registers; reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      wb_data_q    <= '0;
      last_grant_q <= 1'b1;
    end else begin
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      wb_data_q    <= wb_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign RegWrite      = reg_write_q;
  assign rd            = rd_q;
  assign writeBackData = wb_data_q;

  // A read address is pending while any in-flight or queued write targets it.
  always_comb begin
    rs1_pending = (rs1 != '0) &&
                  ((reg_write_q && (rd_q == rs1)) ||
                   (ex_valid && (ex_rd == rs1)) ||
                   (mem_valid && (mem_rd == rs1)));
    rs2_pending = (rs2 != '0) &&
                  ((reg_write_q && (rd_q == rs2)) ||
                   (ex_valid && (ex_rd == rs2)) ||
                   (mem_valid && (mem_rd == rs2)));
  end

endmodule
